// File: rtl/weight_fetch_seq.sv
// Weight ROM sequencer: walks a sync-read ROM and streams words over valid/ready through a
// 2-entry skid FIFO. Define WF_LOOP_EN to replay the ROM num_passes times per start.

module weight_fetch_seq_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       push,
  input logic [1:0] count
);
  // The issue rule reserves a FIFO slot for every outstanding read, so a full FIFO never sees a push.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == 2'd2)));
  a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) count != 2'd3);
endmodule

module weight_fetch_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 2,
  parameter int PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rom_en_q, rom_en_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                    last0_q, last0_d, last1_q, last1_d;
  logic [1:0]              count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    push_s, pop_s, final_rd_s;

`ifdef WF_LOOP_EN
  logic [PASS_WIDTH-1:0]   pass_q, pass_d, passes_q, passes_d;

  // Final read is the last address of the last requested pass.
  always_comb begin
    final_rd_s = (addr_q == LAST_ADDR) && (pass_q == (passes_q - PASS_WIDTH'(1)));
  end
`else
  logic unused_num_passes_s;
  assign unused_num_passes_s = ^num_passes;

  // Single pass: the last ROM address is always the final read.
  always_comb begin
    final_rd_s = (addr_q == LAST_ADDR);
  end
`endif

  // Skid FIFO: slot 0 is the head and drives w_data directly; rd_vld_q marks ROM data on the bus.
  always_comb begin
    push_s  = rd_vld_q;
    pop_s   = valid_q && w_ready;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_s) begin
          data0_d = rom_data;
          last0_d = rd_last_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          data0_d = rom_data;
          last0_d = rd_last_q;
        end else if (push_s) begin
          data1_d = rom_data;
          last1_d = rd_last_q;
          count_d = 2'd2;
        end else if (pop_s) begin
          last0_d = 1'b0;
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s && push_s) begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = rom_data;
          last1_d = rd_last_q;
        end else if (pop_s) begin
          data0_d = data1_q;
          last0_d = last1_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
    valid_d = (count_d != 2'd0);
  end

  // Sequencer: rom_en for the next cycle is decided against next-cycle FIFO occupancy plus the
  // read issued this cycle, which is still in flight then.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rom_en_d  = 1'b0;
    rd_vld_d  = rom_en_q;
    rd_last_d = rom_en_q && final_rd_s;
`ifdef WF_LOOP_EN
    pass_d    = pass_q;
    passes_d  = passes_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          addr_d   = '0;
          rom_en_d = 1'b1;
`ifdef WF_LOOP_EN
          pass_d   = '0;
          passes_d = (num_passes == '0) ? PASS_WIDTH'(1) : num_passes;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (rom_en_q) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
`ifdef WF_LOOP_EN
            pass_d = pass_q + PASS_WIDTH'(1);
`endif
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end else begin
          addr_d = addr_q;
        end
        if (rom_en_q && final_rd_s) begin
          state_d = DRAIN;
        end else begin
          rom_en_d = ((count_d + {1'b0, rom_en_q}) < 2'd2);
        end
      end
      DRAIN: begin
        if ((count_d == 2'd0) && !push_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FETCH) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rom_en_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      count_q   <= 2'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WF_LOOP_EN
      pass_q    <= '0;
      passes_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rom_en_q  <= rom_en_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last0_q   <= last0_d;
      last1_q   <= last1_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef WF_LOOP_EN
      pass_q    <= pass_d;
      passes_q  <= passes_d;
`endif
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = addr_q;
  assign w_valid  = valid_q;
  assign w_data   = data0_q;
  assign w_last   = last0_q;
  assign busy     = busy_q;
  assign done     = done_q;

  weight_fetch_seq_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .count (count_q)
  );

endmodule
